// File: rtl/debounce_bank.sv
// Multi-channel key/switch debouncer: 2-FF synchroniser, tick-gated stability counter,
// registered edge pulses and a per-channel long-press / auto-repeat sequencer.
module debounce_bank #(
    parameter int N_CH       = 4,
    parameter int CNT_N      = 7,
    parameter int IDLE_LEVEL = 1,
    parameter int HOLD_N     = 500,
    parameter int REPEAT_N   = 100
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_tick,
    input  logic [N_CH-1:0] i_in,
    output logic [N_CH-1:0] o_debounced,
    output logic [N_CH-1:0] o_pos,
    output logic [N_CH-1:0] o_neg,
    output logic [N_CH-1:0] o_long,
    output logic [N_CH-1:0] o_rpt
);
    localparam int CW   = (CNT_N > 0) ? $clog2(CNT_N + 1) : 1;
    localparam int HMAX = (HOLD_N > REPEAT_N) ? HOLD_N : REPEAT_N;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic          IDLE_BIT  = (IDLE_LEVEL != 0);
    localparam logic [CW-1:0] CNT_LOAD  = CW'(CNT_N);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [HW-1:0] HOLD_ZERO = {HW{1'b0}};
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_N - 1);
    localparam logic [HW-1:0] RPT_LAST  = HW'(REPEAT_N - 1);

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_WAIT = 2'd1,
        PH_RPT  = 2'd2
    } phase_t;

    logic [N_CH-1:0] sync1_r;
    logic [N_CH-1:0] sync2_r;

    // two-flop synchroniser, clocked every cycle independent of i_tick
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync1_r <= {N_CH{IDLE_BIT}};
            sync2_r <= {N_CH{IDLE_BIT}};
        end else begin
            sync1_r <= i_in;
            sync2_r <= sync1_r;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [CW-1:0] cnt_r, cnt_nx_s;
        logic [HW-1:0] hold_r, hold_nx_s;
        phase_t        phase_r, phase_nx_s;
        logic          deb_r, deb_nx_s, flip_s, pressed_s;
        logic          long_nx_s, rpt_nx_s;
        logic          pos_r, neg_r, long_r, rpt_r;

        assign pressed_s = (deb_r != IDLE_BIT);

        // stability counter: flip only after CNT_N+1 consecutive mismatching ticks
        always_comb begin
            cnt_nx_s = cnt_r;
            deb_nx_s = deb_r;
            flip_s   = 1'b0;
            if (!i_tick) begin
                cnt_nx_s = cnt_r;
            end else if (sync2_r[c] == deb_r) begin
                cnt_nx_s = CNT_LOAD;
            end else if (cnt_r != CNT_ZERO) begin
                cnt_nx_s = cnt_r - CNT_ONE;
            end else begin
                cnt_nx_s = CNT_LOAD;
                deb_nx_s = ~deb_r;
                flip_s   = 1'b1;
            end
        end

        // press sequencer; any flip restarts it, so a release beats a terminal count
        always_comb begin
            phase_nx_s = phase_r;
            hold_nx_s  = hold_r;
            long_nx_s  = 1'b0;
            rpt_nx_s   = 1'b0;
            if (flip_s) begin
                hold_nx_s  = HOLD_ZERO;
                phase_nx_s = pressed_s ? PH_IDLE : PH_WAIT;
            end else if (i_tick && pressed_s) begin
                case (phase_r)
                    PH_WAIT: begin
                        if (hold_r == HOLD_LAST) begin
                            long_nx_s  = 1'b1;
                            hold_nx_s  = HOLD_ZERO;
                            phase_nx_s = PH_RPT;
                        end else begin
                            hold_nx_s = hold_r + HOLD_ONE;
                        end
                    end
                    PH_RPT: begin
                        if (hold_r == RPT_LAST) begin
                            rpt_nx_s  = 1'b1;
                            hold_nx_s = HOLD_ZERO;
                        end else begin
                            hold_nx_s = hold_r + HOLD_ONE;
                        end
                    end
                    default: begin
                        hold_nx_s  = HOLD_ZERO;
                        phase_nx_s = PH_WAIT;
                    end
                endcase
            end else begin
                hold_nx_s = hold_r;
            end
        end

        // channel state and registered pulse outputs
        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                cnt_r   <= CNT_LOAD;
                deb_r   <= IDLE_BIT;
                phase_r <= PH_WAIT;
                hold_r  <= HOLD_ZERO;
                pos_r   <= 1'b0;
                neg_r   <= 1'b0;
                long_r  <= 1'b0;
                rpt_r   <= 1'b0;
            end else begin
                cnt_r   <= cnt_nx_s;
                deb_r   <= deb_nx_s;
                phase_r <= phase_nx_s;
                hold_r  <= hold_nx_s;
                pos_r   <= flip_s & ~deb_r;
                neg_r   <= flip_s & deb_r;
                long_r  <= long_nx_s;
                rpt_r   <= rpt_nx_s;
            end
        end

        assign o_debounced[c] = deb_r;
        assign o_pos[c]       = pos_r;
        assign o_neg[c]       = neg_r;
        assign o_long[c]      = long_r;
        assign o_rpt[c]       = rpt_r;
    end
endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: two instances (short and long hold) driven in parallel and
// compared every cycle against a run-length / press-duration reference model.
module tb_debounce_bank;
    localparam int CNT    = 7;
    localparam int HOLD_A = 5;
    localparam int RPT_A  = 3;
    localparam int HOLD_B = 10;
    localparam int RPT_B  = 3;
    localparam logic [3:0] REL = 4'hF;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick  = 1'b1;
    logic [3:0] in_v  = 4'h0;

    logic [3:0] deb_a, pos_a, neg_a, long_a, rpt_a;
    logic [3:0] deb_b, pos_b, neg_b, long_b, rpt_b;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    logic [3:0] m_s1, m_s2, m_deb, m_pos, m_neg;
    logic [3:0] m_long_a, m_rpt_a, m_long_b, m_rpt_b;
    int         m_run[4];
    int         m_held_a[4];
    int         m_held_b[4];

    logic [39:0] obs_all, exp_all;
    logic [39:0] rst_exp;
    assign obs_all = {deb_a, pos_a, neg_a, long_a, rpt_a, deb_b, pos_b, neg_b, long_b, rpt_b};
    assign exp_all = {m_deb, m_pos, m_neg, m_long_a, m_rpt_a, m_deb, m_pos, m_neg, m_long_b, m_rpt_b};
    assign rst_exp = {REL, 16'h0000, REL, 16'h0000};

    debounce_bank #(.N_CH(4), .CNT_N(CNT), .IDLE_LEVEL(1), .HOLD_N(HOLD_A), .REPEAT_N(RPT_A)) dut_a (
        .i_clk(clk), .i_rst(rst_n), .i_tick(tick), .i_in(in_v),
        .o_debounced(deb_a), .o_pos(pos_a), .o_neg(neg_a), .o_long(long_a), .o_rpt(rpt_a));

    debounce_bank #(.N_CH(4), .CNT_N(CNT), .IDLE_LEVEL(1), .HOLD_N(HOLD_B), .REPEAT_N(RPT_B)) dut_b (
        .i_clk(clk), .i_rst(rst_n), .i_tick(tick), .i_in(in_v),
        .o_debounced(deb_b), .o_pos(pos_b), .o_neg(neg_b), .o_long(long_b), .o_rpt(rpt_b));

    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = REL; m_s2 = REL; m_deb = REL;
        m_pos = 4'h0; m_neg = 4'h0;
        m_long_a = 4'h0; m_rpt_a = 4'h0; m_long_b = 4'h0; m_rpt_b = 4'h0;
        for (int c = 0; c < 4; c++) begin
            m_run[c] = 0; m_held_a[c] = 0; m_held_b[c] = 0;
        end
    endtask

    // flip after CNT+1 consecutive mismatching ticks; pulses from ticks-held-since-press
    task automatic model_step();
        m_pos = 4'h0; m_neg = 4'h0;
        m_long_a = 4'h0; m_rpt_a = 4'h0; m_long_b = 4'h0; m_rpt_b = 4'h0;
        if (tick) begin
            for (int c = 0; c < 4; c++) begin
                logic was_p, fl;
                was_p = !m_deb[c];
                fl = 1'b0;
                if (m_s2[c] != m_deb[c]) begin
                    m_run[c]++;
                    if (m_run[c] == CNT + 1) fl = 1'b1;
                end else begin
                    m_run[c] = 0;
                end
                if (fl) begin
                    m_run[c] = 0;
                    m_pos[c] = !m_deb[c];
                    m_neg[c] = m_deb[c];
                    m_deb[c] = !m_deb[c];
                    m_held_a[c] = 0;
                    m_held_b[c] = 0;
                end else if (was_p) begin
                    m_held_a[c]++;
                    m_held_b[c]++;
                    m_long_a[c] = (m_held_a[c] == HOLD_A);
                    m_rpt_a[c]  = (m_held_a[c] > HOLD_A) && ((m_held_a[c] - HOLD_A) % RPT_A == 0);
                    m_long_b[c] = (m_held_b[c] == HOLD_B);
                    m_rpt_b[c]  = (m_held_b[c] > HOLD_B) && ((m_held_b[c] - HOLD_B) % RPT_B == 0);
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = in_v;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_v = 4'h0; tick = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (obs_all !== rst_exp) begin
            miscompares++;
            $display("FAIL reset_values got=%h want=%h", obs_all, rst_exp);
        end
        rst_n = 1'b1;
        for (int n = 0; n < 14; n++) begin
            logic [3:0] e_deb, e_neg;
            advance();
            vectors++;
            if (obs_all !== exp_all) begin
                miscompares++;
                $display("FAIL reset_model n=%0d got=%h want=%h", n, obs_all, exp_all);
            end
            e_deb = (n >= 9) ? 4'h0 : 4'hF;
            e_neg = (n == 9) ? 4'hF : 4'h0;
            vectors++;
            if ({deb_a, neg_a} !== {e_deb, e_neg}) begin
                miscompares++;
                $display("FAIL reset_flip n=%0d got=%h want=%h", n, {deb_a, neg_a}, {e_deb, e_neg});
            end
        end
    endtask

    task automatic test_bounce();
        int t_last, neg_at, neg_cnt, pos_cnt;
        in_v = REL; tick = 1'b1;
        for (int i = 0; i < 20; i++) begin
            advance();
            vectors++;
            if (obs_all !== exp_all) begin
                miscompares++;
                $display("FAIL bounce_release i=%0d got=%h want=%h", i, obs_all, exp_all);
            end
        end
        t_last = -1; neg_at = -1; neg_cnt = 0; pos_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (i <= 36 && i % 3 == 0) begin
                in_v[0] = ~in_v[0];
                t_last = i;
            end
            advance();
            if (neg_a[0]) begin neg_cnt++; neg_at = i; end
            if (pos_a[0]) pos_cnt++;
            vectors++;
            if (obs_all !== exp_all) begin
                miscompares++;
                $display("FAIL bounce_model i=%0d got=%h want=%h", i, obs_all, exp_all);
            end
        end
        vectors++;
        if (neg_cnt !== 1 || pos_cnt !== 0) begin
            miscompares++;
            $display("FAIL bounce_count got neg=%0d pos=%0d want neg=1 pos=0", neg_cnt, pos_cnt);
        end
        vectors++;
        if (neg_at !== t_last + 9) begin
            miscompares++;
            $display("FAIL bounce_latency got=%0d want=%0d", neg_at, t_last + 9);
        end
    endtask

    task automatic test_tick_gating();
        int flip_at;
        logic [3:0] prev;
        logic t;
        in_v = REL; tick = 1'b1;
        for (int i = 0; i < 20; i++) begin
            advance();
            vectors++;
            if (obs_all !== exp_all) begin
                miscompares++;
                $display("FAIL tick_release i=%0d got=%h want=%h", i, obs_all, exp_all);
            end
        end
        flip_at = -1;
        in_v[1] = 1'b0;
        for (int n = 0; n < 60; n++) begin
            t = (n % 4 == 0);
            tick = t;
            prev = deb_a;
            advance();
            if (neg_a[1]) flip_at = n;
            vectors++;
            if (obs_all !== exp_all) begin
                miscompares++;
                $display("FAIL tick_model n=%0d got=%h want=%h", n, obs_all, exp_all);
            end
            if (!t) begin
                vectors++;
                if (deb_a !== prev) begin
                    miscompares++;
                    $display("FAIL tick_hold n=%0d got=%h want=%h", n, deb_a, prev);
                end
            end
        end
        tick = 1'b1;
        vectors++;
        if (flip_at !== 32) begin
            miscompares++;
            $display("FAIL tick_latency got=%0d want=32", flip_at);
        end
    endtask

    task automatic test_long_repeat();
        logic [5:0] e;
        in_v = REL; tick = 1'b1;
        for (int i = 0; i < 20; i++) begin
            advance();
            vectors++;
            if (obs_all !== exp_all) begin
                miscompares++;
                $display("FAIL long_release i=%0d got=%h want=%h", i, obs_all, exp_all);
            end
        end
        for (int n = 0; n < 50; n++) begin
            in_v[2] = (n < 17) ? 1'b0 : 1'b1;
            advance();
            vectors++;
            if (obs_all !== exp_all) begin
                miscompares++;
                $display("FAIL long_model n=%0d got=%h want=%h", n, obs_all, exp_all);
            end
            e = {n == 9, n == 26, n == 14, (n == 17 || n == 20 || n == 23),
                 n == 19, (n == 22 || n == 25)};
            vectors++;
            if ({neg_a[2], pos_a[2], long_a[2], rpt_a[2], long_b[2], rpt_b[2]} !== e) begin
                miscompares++;
                $display("FAIL long_timing n=%0d got=%b want=%b", n,
                         {neg_a[2], pos_a[2], long_a[2], rpt_a[2], long_b[2], rpt_b[2]}, e);
            end
        end
    endtask

    task automatic test_release_terminal();
        logic [3:0] e;
        in_v = REL; tick = 1'b1;
        for (int i = 0; i < 20; i++) begin
            advance();
            vectors++;
            if (obs_all !== exp_all) begin
                miscompares++;
                $display("FAIL term_release i=%0d got=%h want=%h", i, obs_all, exp_all);
            end
        end
        for (int n = 0; n < 56; n++) begin
            in_v[1] = (n < 10 || n >= 30) ? 1'b0 : 1'b1;
            advance();
            vectors++;
            if (obs_all !== exp_all) begin
                miscompares++;
                $display("FAIL term_model n=%0d got=%h want=%h", n, obs_all, exp_all);
            end
            e = {(n == 9 || n == 39), n == 19, n == 49, (n == 52 || n == 55)};
            vectors++;
            if ({neg_b[1], pos_b[1], long_b[1], rpt_b[1]} !== e) begin
                miscompares++;
                $display("FAIL term_timing n=%0d got=%b want=%b", n,
                         {neg_b[1], pos_b[1], long_b[1], rpt_b[1]}, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] e;
        in_v = REL; tick = 1'b1;
        for (int i = 0; i < 20; i++) begin
            advance();
            vectors++;
            if (obs_all !== exp_all) begin
                miscompares++;
                $display("FAIL areset_release i=%0d got=%h want=%h", i, obs_all, exp_all);
            end
        end
        in_v[3] = 1'b0;
        for (int n = 0; n < 23; n++) begin
            advance();
            vectors++;
            if (obs_all !== exp_all) begin
                miscompares++;
                $display("FAIL areset_press n=%0d got=%h want=%h", n, obs_all, exp_all);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (obs_all !== rst_exp) begin
            miscompares++;
            $display("FAIL areset_immediate got=%h want=%h", obs_all, rst_exp);
        end
        @(negedge clk);
        vectors++;
        if (obs_all !== rst_exp) begin
            miscompares++;
            $display("FAIL areset_held got=%h want=%h", obs_all, rst_exp);
        end
        rst_n = 1'b1;
        for (int n = 0; n < 21; n++) begin
            advance();
            vectors++;
            if (obs_all !== exp_all) begin
                miscompares++;
                $display("FAIL areset_model n=%0d got=%h want=%h", n, obs_all, exp_all);
            end
            e = {n == 9, n == 14, (n == 17 || n == 20), 1'b0};
            vectors++;
            if ({neg_a[3], long_a[3], rpt_a[3], pos_a[3]} !== e) begin
                miscompares++;
                $display("FAIL areset_repress n=%0d got=%b want=%b", n,
                         {neg_a[3], long_a[3], rpt_a[3], pos_a[3]}, e);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(15) == 0) in_v[c] = ~in_v[c];
            end
            tick = ($urandom_range(3) != 0);
            advance();
            vectors++;
            if (obs_all !== exp_all) begin
                miscompares++;
                $display("FAIL random_model n=%0d got=%h want=%h", n, obs_all, exp_all);
            end
        end
        tick = 1'b1;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_tick_gating();
        test_long_repeat();
        test_release_terminal();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
